gpio_controller: RTL and testbench

GPIO_CONTROLLER -- requirements
Module: gpio_controller

---
 rtl/gpio_controller.sv | 152 +++++++++++++++
 tb/tb_gpio_controller.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/gpio_controller.sv
// -----------------------------------------------------------------------------
// gpio_controller
//   Memory-mapped GPIO block with per-pin direction/output registers, a 2-flop
//   input synchronizer, edge detection and a sticky W1C interrupt status.
//
//   Register map (word index on addr):
//     0 DIR      RW   pin output enables
//     1 OUT      RW   pin output values
//     2 IN       RO   synchronized pin inputs
//     3 RISE_EN  RW   rising-edge interrupt enables
//     4 FALL_EN  RW   falling-edge interrupt enables
//     5 STATUS   W1C  sticky edge events
//     6 TOGGLE   WO   writing 1 inverts the matching OUT bit
//     7 reserved
//
//   Ports:
//     clk      rising-edge clock
//     reset    asynchronous active-low reset
//     addr     register word index
//     we/be    write strobe and byte enables (be[k] qualifies wData[8k+7:8k])
//     wData    write data
//     re       read strobe; rData loads on the edge where re = 1, else holds
//     rData    registered read data
//     gpioIn   asynchronous pin inputs
//     gpioOut  pin output values (OUT register)
//     gpioOe   pin output enables (DIR register)
//     irq      level interrupt, |(STATUS & (RISE_EN | FALL_EN))
// -----------------------------------------------------------------------------

// Per-pin input path: synchronizer, edge detector and sticky status bit.
module gpio_pin (
   input  logic clk,
   input  logic reset,
   input  logic pin,
   input  logic rise_en,
   input  logic fall_en,
   input  logic clr,
   output logic in_sync,
   output logic status
);
   logic sync1, prev, ev;

   assign ev = (in_sync & ~prev & rise_en) | (~in_sync & prev & fall_en);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         sync1   <= 1'b0;
         in_sync <= 1'b0;
         prev    <= 1'b0;
         status  <= 1'b0;
      end else begin
         sync1   <= pin;
         in_sync <= sync1;
         prev    <= in_sync;
         // set term last so a same-cycle event beats a W1C clear
         status  <= (status & ~clr) | ev;
      end
   end
endmodule

module gpio_controller #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [2:0]       addr,
   input  logic             we,
   input  logic [3:0]       be,
   input  logic [31:0]      wData,
   input  logic             re,
   output logic [31:0]      rData,
   input  logic [WIDTH-1:0] gpioIn,
   output logic [WIDTH-1:0] gpioOut,
   output logic [WIDTH-1:0] gpioOe,
   output logic             irq
);
   localparam logic [2:0] A_DIR    = 3'd0;
   localparam logic [2:0] A_OUT    = 3'd1;
   localparam logic [2:0] A_IN     = 3'd2;
   localparam logic [2:0] A_RISE   = 3'd3;
   localparam logic [2:0] A_FALL   = 3'd4;
   localparam logic [2:0] A_STATUS = 3'd5;
   localparam logic [2:0] A_TOGGLE = 3'd6;

   logic [WIDTH-1:0] dir, dout, rise_en, fall_en;
   logic [WIDTH-1:0] in_sync, status, st_clr;
   logic [WIDTH-1:0] wm, wbits;
   logic [31:0]      bmask, wmd, rd_mux;
   logic             unused_bits;

   // Byte-lane mask expanded to bits; lanes above WIDTH simply fall off.
   assign bmask = {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
   assign wmd   = wData & bmask;
   assign wm    = bmask[WIDTH-1:0];
   assign wbits = wmd[WIDTH-1:0];
   assign unused_bits = ^{bmask, wmd};

   assign st_clr = (we && addr == A_STATUS) ? wbits : '0;

   gpio_pin u_pin [WIDTH-1:0] (
      .clk     (clk),
      .reset   (reset),
      .pin     (gpioIn),
      .rise_en (rise_en),
      .fall_en (fall_en),
      .clr     (st_clr),
      .in_sync (in_sync),
      .status  (status)
   );

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         dir     <= '0;
         dout    <= '0;
         rise_en <= '0;
         fall_en <= '0;
      end else if (we) begin
         case (addr)
            A_DIR:    dir     <= (dir & ~wm) | wbits;
            A_OUT:    dout    <= (dout & ~wm) | wbits;
            A_RISE:   rise_en <= (rise_en & ~wm) | wbits;
            A_FALL:   fall_en <= (fall_en & ~wm) | wbits;
            A_TOGGLE: dout    <= dout ^ wbits;
            default:  ;
         endcase
      end
   end

   // Read mux sees pre-edge register values, so a read racing a write
   // returns the old contents.
   always_comb begin
      rd_mux = '0;
      case (addr)
         A_DIR:    rd_mux[WIDTH-1:0] = dir;
         A_OUT:    rd_mux[WIDTH-1:0] = dout;
         A_IN:     rd_mux[WIDTH-1:0] = in_sync;
         A_RISE:   rd_mux[WIDTH-1:0] = rise_en;
         A_FALL:   rd_mux[WIDTH-1:0] = fall_en;
         A_STATUS: rd_mux[WIDTH-1:0] = status;
         default:  rd_mux = '0;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset)  rData <= '0;
      else if (re) rData <= rd_mux;
   end

   assign gpioOe  = dir;
   assign gpioOut = dout;
   assign irq     = |(status & (rise_en | fall_en));
endmodule

// File: tb/tb_gpio_controller.sv
// -----------------------------------------------------------------------------
// tb_gpio_controller
//   Self-checking bench for gpio_controller (WIDTH = 8). Directed scenarios plus
//   a randomized run checked against a register-level model that tracks pin
//   samples as a history queue.
// -----------------------------------------------------------------------------
module tb_gpio_controller;
   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic [2:0]  addr = '0;
   logic        we = 1'b0;
   logic [3:0]  be = '0;
   logic [31:0] wData = '0;
   logic        re = 1'b0;
   logic [31:0] rData;
   logic [7:0]  gpioIn = '0;
   logic [7:0]  gpioOut, gpioOe;
   logic        irq;

   int tests = 0;
   int fails = 0;

   gpio_controller #(.WIDTH(8)) dut (
      .clk(clk), .reset(reset), .addr(addr), .we(we), .be(be), .wData(wData),
      .re(re), .rData(rData), .gpioIn(gpioIn), .gpioOut(gpioOut),
      .gpioOe(gpioOe), .irq(irq)
   );

   always #5 clk = ~clk;

   // Model state. hist[0] is the pin value sampled at the most recent edge.
   logic [7:0]  m_dir, m_out, m_rise, m_fall, m_stat;
   logic [31:0] m_rdata;
   logic [7:0]  hist[$];

   task automatic model_reset();
      m_dir = 0; m_out = 0; m_rise = 0; m_fall = 0; m_stat = 0; m_rdata = 0;
      hist = {8'h00, 8'h00, 8'h00};
   endtask

   function automatic logic [7:0] model_read(input logic [2:0] a);
      case (a)
         3'd0: return m_dir;
         3'd1: return m_out;
         3'd2: return hist[1];   // two edges behind the pin
         3'd3: return m_rise;
         3'd4: return m_fall;
         3'd5: return m_stat;
         default: return 8'h00;
      endcase
   endfunction

   function automatic logic model_irq();
      return |(m_stat & (m_rise | m_fall));
   endfunction

   // One bus cycle: update model from pre-edge state, drive DUT, step an edge.
   task automatic tick(input logic w, input logic r, input logic [2:0] a,
                       input logic [3:0] b, input logic [31:0] d, input logic [7:0] p);
      logic [31:0] lanes;
      logic [7:0]  wm, wd, nw, od, ev, clr;
      for (int k = 0; k < 4; k++) lanes[8*k +: 8] = b[k] ? 8'hFF : 8'h00;
      wm = lanes[7:0];
      wd = d[7:0] & wm;
      nw = hist[1];
      od = hist[2];
      ev = (nw & ~od & m_rise) | (~nw & od & m_fall);
      if (r) m_rdata = {24'h0, model_read(a)};
      clr = 8'h00;
      if (w) begin
         case (a)
            3'd0: m_dir  = (m_dir  & ~wm) | wd;
            3'd1: m_out  = (m_out  & ~wm) | wd;
            3'd3: m_rise = (m_rise & ~wm) | wd;
            3'd4: m_fall = (m_fall & ~wm) | wd;
            3'd5: clr = wd;
            3'd6: m_out = m_out ^ wd;
            default: ;
         endcase
      end
      m_stat = (m_stat & ~clr) | ev;
      hist.push_front(p);
      void'(hist.pop_back());
      we = w; re = r; addr = a; be = b; wData = d; gpioIn = p;
      @(posedge clk);
      #1;
      we = 1'b0; re = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b0;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      tests++; if (gpioOe !== 8'h00) begin fails++; $display("FAIL reset_oe got=%h exp=00", gpioOe); end
      tests++; if (gpioOut !== 8'h00) begin fails++; $display("FAIL reset_out got=%h exp=00", gpioOut); end
      tests++; if (irq !== 1'b0) begin fails++; $display("FAIL reset_irq got=%b exp=0", irq); end
      tests++; if (rData !== 32'h0) begin fails++; $display("FAIL reset_rdata got=%h exp=0", rData); end
      reset = 1'b1;
      #2;
   endtask

   task automatic test_dir_out();
      tick(1, 0, 3'd0, 4'b0001, 32'h0F, 8'h00);
      tick(1, 0, 3'd1, 4'b0001, 32'hA5, 8'h00);
      tests++; if (gpioOe !== 8'h0F) begin fails++; $display("FAIL dir_oe got=%h exp=0f", gpioOe); end
      tests++; if (gpioOut !== 8'hA5) begin fails++; $display("FAIL out_val got=%h exp=a5", gpioOut); end
      tick(0, 1, 3'd1, 4'b0000, 32'h0, 8'h00);
      tests++; if (rData !== 32'h000000A5) begin fails++; $display("FAIL read_out got=%h exp=000000a5", rData); end
      tick(0, 1, 3'd0, 4'b0000, 32'h0, 8'h00);
      tests++; if (rData !== 32'h0000000F) begin fails++; $display("FAIL read_dir got=%h exp=0000000f", rData); end
   endtask

   task automatic test_toggle();
      tick(1, 0, 3'd6, 4'b0001, 32'hFF, 8'h00);
      tests++; if (gpioOut !== 8'h5A) begin fails++; $display("FAIL toggle got=%h exp=5a", gpioOut); end
      tick(1, 0, 3'd1, 4'b0010, 32'h1234, 8'h00);
      tests++; if (gpioOut !== 8'h5A) begin fails++; $display("FAIL out_hi_lane got=%h exp=5a", gpioOut); end
      tick(0, 1, 3'd6, 4'b0000, 32'h0, 8'h00);
      tests++; if (rData !== 32'h0) begin fails++; $display("FAIL toggle_read got=%h exp=0", rData); end
   endtask

   task automatic test_rise();
      tick(1, 0, 3'd3, 4'b0001, 32'h01, 8'h00);
      tick(0, 0, 3'd0, 4'b0000, 32'h0, 8'h01);   // edge N: sync1 captures
      tests++; if (irq !== 1'b0) begin fails++; $display("FAIL rise_n got=%b exp=0", irq); end
      tick(0, 0, 3'd0, 4'b0000, 32'h0, 8'h01);   // N+1
      tests++; if (irq !== 1'b0) begin fails++; $display("FAIL rise_n1 got=%b exp=0", irq); end
      tick(0, 1, 3'd2, 4'b0000, 32'h0, 8'h01);   // N+2
      tests++; if (irq !== 1'b1) begin fails++; $display("FAIL rise_n2 got=%b exp=1", irq); end
      tests++; if (rData !== 32'h1) begin fails++; $display("FAIL in_after_n1 got=%h exp=1", rData); end
      tick(1, 1, 3'd5, 4'b0001, 32'h01, 8'h01);  // read races W1C
      tests++; if (rData !== 32'h1) begin fails++; $display("FAIL status_prewrite got=%h exp=1", rData); end
      tests++; if (irq !== 1'b0) begin fails++; $display("FAIL w1c_irq got=%b exp=0", irq); end
      tick(0, 1, 3'd5, 4'b0000, 32'h0, 8'h01);
      tests++; if (rData !== 32'h0) begin fails++; $display("FAIL status_cleared got=%h exp=0", rData); end
   endtask

   task automatic test_fall_collision();
      tick(1, 0, 3'd4, 4'b0001, 32'h80, 8'h81);
      tick(0, 0, 3'd0, 4'b0000, 32'h0, 8'h81);
      tick(0, 0, 3'd0, 4'b0000, 32'h0, 8'h81);
      tick(0, 0, 3'd0, 4'b0000, 32'h0, 8'h01);   // N: pin7 falls
      tick(0, 0, 3'd0, 4'b0000, 32'h0, 8'h01);   // N+1
      tests++; if (irq !== 1'b0) begin fails++; $display("FAIL fall_n1 got=%b exp=0", irq); end
      tick(1, 0, 3'd5, 4'b0001, 32'h80, 8'h01);  // N+2 with coinciding clear
      tests++; if (irq !== 1'b1) begin fails++; $display("FAIL event_wins_irq got=%b exp=1", irq); end
      tick(0, 1, 3'd5, 4'b0000, 32'h0, 8'h01);
      tests++; if (rData !== 32'h80) begin fails++; $display("FAIL event_wins_stat got=%h exp=80", rData); end
      tick(1, 0, 3'd4, 4'b0001, 32'h00, 8'h01);  // disable masks irq only
      tests++; if (irq !== 1'b0) begin fails++; $display("FAIL mask_irq got=%b exp=0", irq); end
      tick(0, 1, 3'd5, 4'b0000, 32'h0, 8'h01);
      tests++; if (rData !== 32'h80) begin fails++; $display("FAIL mask_keeps_stat got=%h exp=80", rData); end
      tick(1, 0, 3'd5, 4'b1111, 32'hFFFF_FFFF, 8'h01);
   endtask

   task automatic test_read_misc();
      repeat (3) tick(0, 0, 3'd0, 4'b0000, 32'h0, 8'h3C);
      tick(1, 1, 3'd2, 4'b1111, 32'hFF, 8'h3C);  // IN write ignored
      tests++; if (rData !== 32'h3C) begin fails++; $display("FAIL read_in got=%h exp=3c", rData); end
      tick(1, 1, 3'd6, 4'b0000, 32'hFF, 8'h3C);  // no lanes: no toggle
      tests++; if (rData !== 32'h0) begin fails++; $display("FAIL read_a6 got=%h exp=0", rData); end
      tick(0, 1, 3'd2, 4'b0000, 32'h0, 8'h3C);
      tests++; if (rData !== 32'h3C) begin fails++; $display("FAIL in_unwritten got=%h exp=3c", rData); end
      tick(1, 1, 3'd7, 4'b1111, 32'hFF, 8'h3C);
      tests++; if (rData !== 32'h0) begin fails++; $display("FAIL read_a7 got=%h exp=0", rData); end
      tests++; if (gpioOut !== 8'h5A || gpioOe !== 8'h0F) begin
         fails++; $display("FAIL reserved_write out=%h oe=%h exp=5a/0f", gpioOut, gpioOe);
      end
   endtask

   task automatic test_random();
      logic [7:0] p;
      p = 8'h3C;
      for (int i = 0; i < 400; i++) begin
         if ($urandom_range(0, 3) == 0) p = 8'($urandom);
         tick(1'($urandom), 1'($urandom), 3'($urandom_range(0, 7)), 4'($urandom),
              $urandom, p);
         tests++; if (gpioOe !== m_dir) begin fails++; $display("FAIL rnd_oe i=%0d got=%h exp=%h", i, gpioOe, m_dir); end
         tests++; if (gpioOut !== m_out) begin fails++; $display("FAIL rnd_out i=%0d got=%h exp=%h", i, gpioOut, m_out); end
         tests++; if (irq !== model_irq()) begin fails++; $display("FAIL rnd_irq i=%0d got=%b exp=%b", i, irq, model_irq()); end
         tests++; if (rData !== m_rdata) begin fails++; $display("FAIL rnd_rdata i=%0d got=%h exp=%h", i, rData, m_rdata); end
      end
   endtask

   task automatic test_async_reset();
      tick(1, 0, 3'd3, 4'b0001, 32'hFF, 8'h00);
      tick(0, 0, 3'd0, 4'b0000, 32'h0, 8'h00);
      tick(0, 0, 3'd0, 4'b0000, 32'h0, 8'h00);
      repeat (3) tick(0, 0, 3'd0, 4'b0000, 32'h0, 8'hFF);
      tick(0, 1, 3'd3, 4'b0000, 32'h0, 8'hFF);
      tests++; if (irq !== 1'b1) begin fails++; $display("FAIL pre_reset_irq got=%b exp=1", irq); end
      tests++; if (rData !== 32'hFF) begin fails++; $display("FAIL pre_reset_rdata got=%h exp=ff", rData); end
      #2 reset = 1'b0;
      #1;
      tests++; if (irq !== 1'b0) begin fails++; $display("FAIL async_irq got=%b exp=0", irq); end
      tests++; if (gpioOe !== 8'h00 || gpioOut !== 8'h00) begin
         fails++; $display("FAIL async_pins oe=%h out=%h exp=00/00", gpioOe, gpioOut);
      end
      tests++; if (rData !== 32'h0) begin fails++; $display("FAIL async_rdata got=%h exp=0", rData); end
      #2 reset = 1'b1;
      model_reset();
      // Pins stay high: the post-reset rise is seen but RISE_EN is now 0.
      for (int a = 0; a < 8; a++) begin
         tick(0, 1, 3'(a), 4'b0000, 32'h0, 8'hFF);
         tests++; if (rData !== m_rdata) begin fails++; $display("FAIL post_reset_read a=%0d got=%h exp=%h", a, rData, m_rdata); end
      end
      tick(0, 1, 3'd5, 4'b0000, 32'h0, 8'hFF);
      tests++; if (rData !== 32'h0 || irq !== 1'b0) begin
         fails++; $display("FAIL ignored_rise stat=%h irq=%b exp=0/0", rData, irq);
      end
      tick(0, 1, 3'd2, 4'b0000, 32'h0, 8'hFF);
      tests++; if (rData !== 32'hFF) begin fails++; $display("FAIL post_reset_in got=%h exp=ff", rData); end
   endtask

   initial begin
      test_reset();
      test_dir_out();
      test_toggle();
      test_rise();
      test_fall_collision();
      test_read_misc();
      test_random();
      test_async_reset();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
